cla_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract unit; successor to the fixed 32-bit single-cycle lookahead adder.

---
 rtl/cla_pkg.sv | 12 +
 rtl/cla_block.sv | 57 +++++
 rtl/cla_pipe.sv | 114 +++++++++++
 tb/tb_cla_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared defaults and helpers for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;

  localparam int CLA_WIDTH_DEF = 32;
  localparam int CLA_BLOCK_DEF = 8;

  // Number of lookahead segments, which is also the pipeline depth.
  function automatic int nseg(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead adder: every internal carry is a
// flat sum-of-products of generate/propagate terms and the block carry-in.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = CLA_BLOCK_DEF
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic [BLOCK-1:0] g,
  output logic [BLOCK-1:0] p,
  output logic             gout,
  output logic             pout,
  output logic             cout
);

  logic [BLOCK-1:0] grp_g;
  logic [BLOCK-1:0] grp_p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a | b;

  // grp_g[i]/grp_p[i]: group generate/propagate over bits 0..i.
  always_comb begin
    logic term;
    grp_g = '0;
    grp_p = '0;
    term  = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      grp_p[i] = 1'b1;
      for (int k = 0; k <= i; k++) begin
        grp_p[i] = grp_p[i] & p[k];
      end
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & p[k];
        end
        grp_g[i] = grp_g[i] | term;
      end
    end
  end

  assign c[0] = cin;
  for (genvar gi = 0; gi < BLOCK; gi++) begin : g_carry
    assign c[gi+1] = grp_g[gi] | (grp_p[gi] & cin);
  end

  assign s    = a ^ b ^ c[BLOCK-1:0];
  assign gout = grp_g[BLOCK-1];
  assign pout = grp_p[BLOCK-1];
  assign cout = c[BLOCK];

endmodule

// File: rtl/cla_pipe.sv
// Pipelined add/subtract unit: one lookahead segment resolved per stage, carry
// registered between stages, global-stall valid/ready handshake.
module cla_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = CLA_WIDTH_DEF,
  parameter int BLOCK = CLA_BLOCK_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, BLOCK);
  localparam int MSB  = WIDTH - 1;

  if ((WIDTH % BLOCK) != 0 || NSEG < 1) begin : g_bad_cfg
    $error("cla_pipe: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic adv;
  logic bx_msb;

  // Whole pipe moves as one; a stalled output freezes every stage.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_b, src_sum;
    logic             src_sub, src_cin, src_valid;
    logic [WIDTH-1:0] seg_wide, sum_next;
    logic [BLOCK-1:0] seg_s, unused_g, unused_p;
    logic             seg_cout, unused_gout, unused_pout;
    logic             valid_reg, sub_reg, carry_reg;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;

    if (gi == 0) begin : g_head
      assign src_a     = in_a;
      assign src_b     = in_b;
      assign src_sub   = in_sub;
      assign src_cin   = in_sub | in_cin;
      assign src_valid = in_valid;
      assign src_sum   = '0;
    end else begin : g_tail
      assign src_a     = g_stage[gi-1].a_reg;
      assign src_b     = g_stage[gi-1].b_reg;
      assign src_sub   = g_stage[gi-1].sub_reg;
      assign src_cin   = g_stage[gi-1].carry_reg;
      assign src_valid = g_stage[gi-1].valid_reg;
      assign src_sum   = g_stage[gi-1].sum_reg;
    end

    cla_block #(.BLOCK(BLOCK)) u_block (
      .a    (src_a[gi*BLOCK +: BLOCK]),
      .b    (src_b[gi*BLOCK +: BLOCK] ^ {BLOCK{src_sub}}),
      .cin  (src_cin),
      .s    (seg_s),
      .g    (unused_g),
      .p    (unused_p),
      .gout (unused_gout),
      .pout (unused_pout),
      .cout (seg_cout)
    );

    // Bits at and above this segment are still zero in src_sum, so OR merges.
    always_comb begin
      seg_wide = '0;
      seg_wide[gi*BLOCK +: BLOCK] = seg_s;
      sum_next = src_sum | seg_wide;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        valid_reg <= 1'b0;
        sub_reg   <= 1'b0;
        carry_reg <= 1'b0;
        a_reg     <= '0;
        b_reg     <= '0;
        sum_reg   <= '0;
      end else if (adv) begin
        valid_reg <= src_valid;
        sub_reg   <= src_sub;
        carry_reg <= seg_cout;
        a_reg     <= src_a;
        b_reg     <= src_b;
        sum_reg   <= sum_next;
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_reg;
  assign out_sum   = g_stage[NSEG-1].sum_reg;
  assign out_cout  = g_stage[NSEG-1].carry_reg;
  assign out_and   = g_stage[NSEG-1].a_reg & g_stage[NSEG-1].b_reg;
  assign out_or    = g_stage[NSEG-1].a_reg | g_stage[NSEG-1].b_reg;

  // Overflow looks at the effective (possibly inverted) B operand.
  assign bx_msb  = g_stage[NSEG-1].b_reg[MSB] ^ g_stage[NSEG-1].sub_reg;
  assign out_ovf = (g_stage[NSEG-1].a_reg[MSB] == bx_msb) &&
                   (g_stage[NSEG-1].sum_reg[MSB] != g_stage[NSEG-1].a_reg[MSB]);

endmodule

// File: tb/tb_cla_pipe.sv
// Self-checking bench for cla_pipe: directed vector table, streaming,
// backpressure, mid-flight reset, plus a single-segment instance.
module tb_cla_pipe;

  localparam int W  = 32;
  localparam int NS = 4;
  localparam int W1 = 16;

  logic          clk, rst;
  logic          in_valid, in_ready, in_sub, in_cin;
  logic          out_valid, out_ready, out_cout, out_ovf;
  logic [W-1:0]  in_a, in_b, out_sum, out_and, out_or;
  logic          in_valid1, in_ready1, in_sub1, in_cin1;
  logic          out_valid1, out_ready1, out_cout1, out_ovf1;
  logic [W1-1:0] in_a1, in_b1, out_sum1, out_and1, out_or1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int delivered = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit accepted;

  typedef struct {
    logic [W-1:0] sum, andv, orv;
    logic         cout, ovf;
    int           t;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         sub, cin;
    logic [W-1:0] sum, andv, orv;
    logic         cout, ovf;
  } vec_t;

  exp_t exp_q[$];
  exp_t pending;
  vec_t vecs[10];
  logic [W-1:0] sa[100], sb[100];
  logic         ssub[100], scin[100];

  cla_pipe #(.WIDTH(W), .BLOCK(8)) u_dut (
    .clock(clk), .reset(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_and(out_and), .out_or(out_or),
    .out_cout(out_cout), .out_ovf(out_ovf)
  );

  cla_pipe #(.WIDTH(W1), .BLOCK(16)) u_dut1 (
    .clock(clk), .reset(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_sub(in_sub1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_and(out_and1), .out_or(out_or1),
    .out_cout(out_cout1), .out_ovf(out_ovf1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         e;
    logic [W-1:0] bx;
    logic [W:0]   full;
    bx     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (sub | cin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
    e.andv = a & b;
    e.orv  = a | b;
    e.t    = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock cycle: settle, score a delivery, log an acceptance, advance.
  task automatic do_cycle(input bit chk_lat);
    exp_t e;
    #1;
    accepted = in_valid && in_ready;
    if (out_valid && out_ready) begin
      $display("txn out: sum=%h and=%h or=%h cout=%b ovf=%b", out_sum, out_and, out_or, out_cout, out_ovf);
      if (delivered == 0) first_cyc = cyc;
      last_cyc = cyc;
      delivered++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out: got sum=%h expected no result", out_sum);
      end else begin
        e = exp_q.pop_front();
        if (out_sum !== e.sum || out_and !== e.andv || out_or !== e.orv ||
            out_cout !== e.cout || out_ovf !== e.ovf) begin
          errors++;
          $display("FAIL result: got sum=%h and=%h or=%h cout=%b ovf=%b expected sum=%h and=%h or=%h cout=%b ovf=%b",
                   out_sum, out_and, out_or, out_cout, out_ovf, e.sum, e.andv, e.orv, e.cout, e.ovf);
        end
        if (chk_lat) begin
          checks++;
          if (cyc - e.t != NS) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d", cyc - e.t, NS);
          end
        end
      end
    end
    if (accepted) begin
      e   = pending;
      e.t = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic set_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    pending = model(a, b, sub, cin);
  endtask

  task automatic send_hold(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic cin);
    set_op(a, b, sub, cin);
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 50 && !accepted; k++) do_cycle(1'b0);
    if (!accepted) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit chk_lat);
    in_valid = 1'b0;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) do_cycle(chk_lat);
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    int n_sent;
    int seen;

    //            a             b             sub   cin   sum           and           or            cout  ovf
    vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0001, 1'b1, 1'b1};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, 32'h0000_0002, 32'h0000_0001, 32'h0000_0007, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0007, 1'b0, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 32'h1010_1010, 32'h1335_5779, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[7] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0};
    vecs[9] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

    for (int i = 0; i < 100; i++) begin
      sa[i] = $urandom; sb[i] = $urandom;
      ssub[i] = 1'($urandom_range(0, 1)); scin[i] = 1'($urandom_range(0, 1));
    end

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; in_cin = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; in_sub1 = 1'b0; in_cin1 = 1'b0; out_ready1 = 1'b1;
    pending = model('0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_sum", out_sum, 32'd0);
    chk("rst_out_and_or", out_and | out_or, 32'd0);
    chk("rst_cout_ovf", {30'd0, out_cout, out_ovf}, 32'd0);
    chk("rst1_out_valid", {31'd0, out_valid1}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors, one at a time, with latency check.
    for (int i = 0; i < 10; i++) begin
      in_a = vecs[i].a; in_b = vecs[i].b; in_sub = vecs[i].sub; in_cin = vecs[i].cin;
      pending.sum = vecs[i].sum; pending.andv = vecs[i].andv; pending.orv = vecs[i].orv;
      pending.cout = vecs[i].cout; pending.ovf = vecs[i].ovf;
      in_valid = 1'b1;
      do_cycle(1'b1);
      chk("table_accept", {31'd0, accepted}, 32'd1);
      drain(1'b1);
    end

    // Streaming: 100 back-to-back ops, one result per cycle.
    delivered = 0;
    n_sent = 0;
    for (int k = 0; k < 400 && delivered < 100; k++) begin
      if (n_sent < 100) begin
        set_op(sa[n_sent], sb[n_sent], ssub[n_sent], scin[n_sent]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      do_cycle(1'b0);
      if (accepted) n_sent++;
    end
    chk("stream_count", delivered, 32'd100);
    chk("stream_rate", last_cyc - first_cyc, 32'd99);
    drain(1'b0);

    // Backpressure: fill, stall 5 cycles, release.
    for (int k = 0; k < 4; k++) send_hold($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
    set_op($urandom, $urandom, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      if (exp_q.size() > 0) chk("bp_hold_sum", out_sum, exp_q[0].sum);
      do_cycle(1'b0);
      chk("bp_no_accept", {31'd0, accepted}, 32'd0);
    end
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int k = 0; k < 20 && !accepted; k++) do_cycle(1'b0);
    chk("bp_release_accept", {31'd0, accepted}, 32'd1);
    drain(1'b0);

    // Reset with three ops in flight: none may emerge.
    for (int k = 0; k < 3; k++) send_hold($urandom, $urandom, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_sum", out_sum, 32'd0);
    #1;
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      do_cycle(1'b0);
      if (out_valid) seen++;
    end
    chk("midrst_no_emerge", seen, 32'd0);

    // Single-segment instance: result registered once.
    chk("n1_in_ready", {31'd0, in_ready1}, 32'd1);
    in_a1 = 16'hFFFF; in_b1 = 16'h0001; in_sub1 = 1'b0; in_cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_add_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_add_sum", {16'd0, out_sum1}, 32'h0000_0000);
    chk("n1_add_flags", {30'd0, out_cout1, out_ovf1}, 32'd2);
    in_a1 = 16'h8000; in_b1 = 16'h0001; in_sub1 = 1'b1; in_cin1 = 1'b0; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    chk("n1_sub_valid", {31'd0, out_valid1}, 32'd1);
    chk("n1_sub_sum", {16'd0, out_sum1}, 32'h0000_7FFF);
    chk("n1_sub_flags", {30'd0, out_cout1, out_ovf1}, 32'd3);
    chk("n1_sub_andor", {out_and1, out_or1}, 32'h0000_8001);
    @(posedge clk); #1;
    chk("n1_bubble", {31'd0, out_valid1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
